// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock monitors.
package clk_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BYPASS,
        ST_ACQUIRE,
        ST_MEASURE,
        ST_LOCKED,
        ST_FAULT
    } clk_mon_state_t;

    localparam int unsigned DEF_DIV_RATIO = 2;
    localparam int unsigned DEF_LOCK_CNT  = 4;
    localparam int unsigned DEF_TIMEOUT   = 16;

    // Smallest counter width that can hold the value TIMEOUT.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Two-flop history of a flop-driven clock sampled as data; rise_o marks a 0->1 transition.
module clk_edge_det (
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic sig_i,
    output logic rise_o
);

    logic d1_q;
    logic d2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            d1_q <= 1'b0;
            d2_q <= 1'b0;
        end else begin
            d1_q <= sig_i;
            d2_q <= d1_q;
        end
    end

    assign rise_o = d1_q & ~d2_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the divided-clock period in source cycles and reports lock or a sticky fault.
//   state   | meaning
//   IDLE    | monitor disabled, everything cleared
//   BYPASS  | divider bypassed, checking suspended
//   ACQUIRE | waiting for the first rise (partial period discarded)
//   MEASURE | counting consecutive correct periods
//   LOCKED  | divider verified, every period still checked
//   FAULT   | wrong period or timeout, held until i_CLR
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned DIV_RATIO = DEF_DIV_RATIO,
    parameter int unsigned LOCK_CNT  = DEF_LOCK_CNT,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             i_SRC_CLK,
    input  logic             i_RESETB,
    input  logic             i_EN,
    input  logic             i_BYPASS,
    input  logic             i_CLR,
    input  logic             i_DIV_CLK,
    output logic             o_EDGE,
    output logic [CNT_W-1:0] o_PERIOD,
    output logic             o_LOCK,
    output logic             o_FAULT
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]   TO_VAL    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   DIV_VAL   = CNT_W'(DIV_RATIO);
    localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT - 1);

    if (CNT_W < cnt_width(TIMEOUT)) begin : g_cnt_w_check
        $error("CNT_W too narrow to reach TIMEOUT");
    end

    clk_mon_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               edge_q, lock_q, fault_q;
    logic               rise;
    logic               timeout;

    clk_edge_det u_edge_det (
        .clk_i   (i_SRC_CLK),
        .rst_b_i (i_RESETB),
        .sig_i   (i_DIV_CLK),
        .rise_o  (rise)
    );

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        period_d = period_q;
        timeout  = (cnt_q == TO_VAL) && !rise;
        cnt_d    = cnt_q;
        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != TO_VAL) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Leaving BYPASS or FAULT restarts the timeout window from zero.
        if (!i_EN) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            match_d  = '0;
            period_d = '0;
        end else if (i_BYPASS) begin
            state_d = ST_BYPASS;
            cnt_d   = '0;
            match_d = '0;
        end else if (i_CLR && state_q == ST_FAULT) begin
            state_d = ST_ACQUIRE;
            cnt_d   = '0;
            match_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_ACQUIRE;
                ST_BYPASS:  state_d = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    if (rise) begin
                        state_d = ST_MEASURE;
                        match_d = '0;
                    end else if (timeout) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        if (cnt_q != DIV_VAL) begin
                            match_d = '0;
                        end else if (match_q == LOCK_LAST) begin
                            state_d = ST_LOCKED;
                            match_d = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else if (timeout) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_LOCKED: begin
                    if (rise) begin
                        period_d = cnt_q;
                        if (cnt_q != DIV_VAL) state_d = ST_FAULT;
                    end else if (timeout) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    if (rise) period_d = cnt_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_SRC_CLK) begin
        if (!i_RESETB) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            match_q  <= '0;
            period_q <= '0;
            edge_q   <= 1'b0;
            lock_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            period_q <= period_d;
            edge_q   <= rise;
            lock_q   <= (state_d == ST_LOCKED);
            fault_q  <= (state_d == ST_FAULT);
        end
    end

    assign o_EDGE   = edge_q;
    assign o_PERIOD = period_q;
    assign o_LOCK   = lock_q;
    assign o_FAULT  = fault_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor with default parameters.
module tb_clk_div_monitor;
    import clk_mon_pkg::*;

    logic       clk = 1'b0;
    logic       rstb, en, byp, clr, div;
    logic       div_v;
    logic       dut_edge, dut_lock, dut_fault;
    logic [7:0] dut_period;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    clk_div_monitor #(
        .DIV_RATIO (2),
        .LOCK_CNT  (4),
        .TIMEOUT   (16),
        .CNT_W     (8)
    ) dut (
        .i_SRC_CLK (clk),
        .i_RESETB  (rstb),
        .i_EN      (en),
        .i_BYPASS  (byp),
        .i_CLR     (clr),
        .i_DIV_CLK (div),
        .o_EDGE    (dut_edge),
        .o_PERIOD  (dut_period),
        .o_LOCK    (dut_lock),
        .o_FAULT   (dut_fault)
    );

    typedef struct {
        logic       en, byp, clr, div;
        logic       e_edge, e_lock, e_fault;
        logic [7:0] e_period;
    } vec_t;

    typedef struct {
        logic       e_edge, e_lock, e_fault;
        logic [7:0] e_period;
    } exp_t;

    vec_t vecs[14];
    exp_t sb_q[$];

    function automatic vec_t mk(input logic d, input logic e, input logic l,
                                input logic f, input logic [7:0] p);
        vec_t v;
        v.en = 1'b1; v.byp = 1'b0; v.clr = 1'b0; v.div = d;
        v.e_edge = e; v.e_lock = l; v.e_fault = f; v.e_period = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs just after a falling edge, then wait past the next rising edge.
    task automatic cyc(input logic e, input logic b, input logic c, input logic d);
        en = e; byp = b; clr = c; div = d; div_v = d;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " edge"},   32'(dut_edge),   0);
        chk({name, " period"}, 32'(dut_period), 0);
        chk({name, " lock"},   32'(dut_lock),   0);
        chk({name, " fault"},  32'(dut_fault),  0);
        chk({name, " state"},  32'(dut.state_q), 32'(ST_IDLE));
    endtask

    // Toggle the divided clock every cycle until lock; expect lock on the 5th rise.
    task automatic relock(input string name);
        int rises = 0;
        int n = 0;
        while (!dut_lock && n < 60) begin
            cyc(1'b1, 1'b0, 1'b0, ~div_v);
            if (dut_edge) rises++;
            n++;
        end
        chk({name, " rises to lock"}, 32'(rises), 5);
        chk({name, " lock"},          32'(dut_lock), 1);
        chk({name, " period"},        32'(dut_period), 2);
        chk({name, " fault"},         32'(dut_fault), 0);
    endtask

    initial begin
        exp_t got;
        exp_t want;
        int   n;

        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
        vecs[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
        vecs[13] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd2);

        // Reset with random inputs
        rstb = 1'b0;
        for (int i = 0; i < 2; i++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk_all_zero("reset");
        rstb = 1'b1;

        // Lock acquisition, one row per source cycle
        for (int i = 0; i < 14; i++) begin
            en = vecs[i].en; byp = vecs[i].byp; clr = vecs[i].clr;
            div = vecs[i].div; div_v = vecs[i].div;
            want.e_edge = vecs[i].e_edge; want.e_lock = vecs[i].e_lock;
            want.e_fault = vecs[i].e_fault; want.e_period = vecs[i].e_period;
            sb_q.push_back(want);
            @(negedge clk);
            got = sb_q.pop_front();
            chk($sformatf("vec%0d edge", i),   32'(dut_edge),   32'(got.e_edge));
            chk($sformatf("vec%0d lock", i),   32'(dut_lock),   32'(got.e_lock));
            chk($sformatf("vec%0d fault", i),  32'(dut_fault),  32'(got.e_fault));
            chk($sformatf("vec%0d period", i), 32'(dut_period), 32'(got.e_period));
        end

        // Stuck low after lock: fault 16 cycles after the last rise
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("stuck last rise edge", 32'(dut_edge), 1);
        chk("stuck last rise lock", 32'(dut_lock), 1);
        n = 0;
        while (!dut_fault && n < 40) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("stuck cycles to fault", 32'(n), 16);
        chk("stuck lock", 32'(dut_lock), 0);
        chk("stuck period", 32'(dut_period), 2);

        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr1 fault", 32'(dut_fault), 0);
        relock("clr1");

        // One stretched high phase gives period 3
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("wrong good rise edge", 32'(dut_edge), 1);
        chk("wrong good rise period", 32'(dut_period), 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("wrong before lock", 32'(dut_lock), 1);
        chk("wrong before fault", 32'(dut_fault), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrong edge", 32'(dut_edge), 1);
        chk("wrong period", 32'(dut_period), 3);
        chk("wrong fault", 32'(dut_fault), 1);
        chk("wrong lock", 32'(dut_lock), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("wrong sticky fault", 32'(dut_fault), 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr2 fault", 32'(dut_fault), 0);
        relock("clr2");

        // Bypass mid-lock
        cyc(1'b1, 1'b1, 1'b0, ~div_v);
        chk("bypass lock", 32'(dut_lock), 0);
        chk("bypass fault", 32'(dut_fault), 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, ~div_v);
        chk("bypass hold lock", 32'(dut_lock), 0);
        chk("bypass hold fault", 32'(dut_fault), 0);
        cyc(1'b1, 1'b0, 1'b0, ~div_v);
        chk("bypass exit lock", 32'(dut_lock), 0);
        relock("bypass");

        // Disable wins over clear and bypass
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk_all_zero("priority");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all_zero("disabled");

        // Reset mid-operation
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        relock("pre-reset");
        rstb = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, ~div_v);
        chk_all_zero("mid reset");
        rstb = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
